// File: rtl/uart_pkg.sv
// Shared UART definitions: baud generator state encoding and parameter defaults.
package uart_pkg;

    localparam int unsigned DIVISOR_WIDTH_DEFAULT = 16;
    localparam int unsigned OVERSAMPLE_DEFAULT    = 16;

    typedef enum logic [1:0] {
        BG_IDLE = 2'd0,
        BG_REQ  = 2'd1,
        BG_WAIT = 2'd2,
        BG_RUN  = 2'd3
    } baud_state_t;

endpackage

// File: rtl/tick_counter.sv
// Wrapping counter 0..terminal with a registered one-cycle tick on wrap.
module tick_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // Disabled or cleared: restart from zero and drop any tick in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!en || clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == terminal) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_gen.sv
// Baud generator: requests divisor*OVERSAMPLE from an external multiplier, then
// emits baud16/bit ticks. Optional `BAUD_GEN_RESYNC_EN adds a resync input.
module baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR_WIDTH = DIVISOR_WIDTH_DEFAULT,
    parameter int unsigned OVERSAMPLE    = OVERSAMPLE_DEFAULT,
    localparam int unsigned PERIOD_WIDTH = DIVISOR_WIDTH + 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    input  logic                     div_wr,
`ifdef BAUD_GEN_RESYNC_EN
    input  logic                     resync,
`endif
    output logic                     mult_start,
    output logic [DIVISOR_WIDTH-1:0] mult_multiplicand,
    output logic [7:0]               mult_multiplier,
    input  logic [PERIOD_WIDTH-1:0]  mult_product,
    input  logic                     mult_busy,
    output logic                     baud16_tick,
    output logic                     bit_tick,
    output logic [PERIOD_WIDTH-1:0]  period,
    output logic                     period_valid
);

    baud_state_t              state;
    logic [DIVISOR_WIDTH-1:0] div_latch;
    logic [DIVISOR_WIDTH-1:0] next_div;
    logic                     pending;
    logic                     run_en;
    logic                     cnt_clear;
    logic [DIVISOR_WIDTH-1:0] div_term;
    logic [PERIOD_WIDTH-1:0]  bit_term;

    assign mult_multiplicand = div_latch;
    assign mult_multiplier   = 8'(OVERSAMPLE);
    assign next_div          = div_wr ? divisor : div_latch;
    assign div_term          = div_latch - 1'b1;
    assign bit_term          = period - 1'b1;

    // A divisor write in RUN silences the counters on the very edge it is sampled.
    assign run_en = (state == BG_RUN) && !div_wr;

`ifdef BAUD_GEN_RESYNC_EN
    assign cnt_clear = resync;
`else
    assign cnt_clear = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BG_IDLE;
            div_latch    <= '0;
            pending      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            mult_start   <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            if (div_wr) div_latch <= divisor;
            case (state)
                BG_IDLE: begin
                    if (div_wr && divisor != '0) begin
                        state      <= BG_REQ;
                        mult_start <= 1'b1;
                    end
                end
                BG_REQ: begin
                    state <= BG_WAIT;
                    if (div_wr) pending <= 1'b1;
                end
                BG_WAIT: begin
                    if (!mult_busy) begin
                        pending <= 1'b0;
                        // A write since the request makes this product stale.
                        if (pending || div_wr) begin
                            if (next_div != '0) begin
                                state      <= BG_REQ;
                                mult_start <= 1'b1;
                            end else begin
                                state <= BG_IDLE;
                            end
                        end else begin
                            period       <= mult_product;
                            period_valid <= 1'b1;
                            state        <= BG_RUN;
                        end
                    end else if (div_wr) begin
                        pending <= 1'b1;
                    end
                end
                BG_RUN: begin
                    if (div_wr) begin
                        period_valid <= 1'b0;
                        if (divisor != '0) begin
                            state      <= BG_REQ;
                            mult_start <= 1'b1;
                        end else begin
                            state <= BG_IDLE;
                        end
                    end
                end
                default: state <= BG_IDLE;
            endcase
        end
    end

    tick_counter #(.WIDTH(DIVISOR_WIDTH)) u_div_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_en),
        .clear    (cnt_clear),
        .terminal (div_term),
        .tick     (baud16_tick)
    );

    tick_counter #(.WIDTH(PERIOD_WIDTH)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_en),
        .clear    (cnt_clear),
        .terminal (bit_term),
        .tick     (bit_tick)
    );

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: scenario table, directed corner cases and
// randomized writes/resets checked against a tick-time model.
module tb_baud_gen;

    localparam int unsigned DW = 16;
    localparam int unsigned OS = 16;
    localparam int unsigned PW = DW + 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] divisor;
    logic          div_wr;
`ifdef BAUD_GEN_RESYNC_EN
    logic          resync;
`endif
    logic          mult_start;
    logic [DW-1:0] mult_multiplicand;
    logic [7:0]    mult_multiplier;
    logic [PW-1:0] mult_product;
    logic          mult_busy;
    logic          baud16_tick;
    logic          bit_tick;
    logic [PW-1:0] period;
    logic          period_valid;

    always #5 clk = ~clk;

    baud_gen #(.DIVISOR_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .divisor           (divisor),
        .div_wr            (div_wr),
`ifdef BAUD_GEN_RESYNC_EN
        .resync            (resync),
`endif
        .mult_start        (mult_start),
        .mult_multiplicand (mult_multiplicand),
        .mult_multiplier   (mult_multiplier),
        .mult_product      (mult_product),
        .mult_busy         (mult_busy),
        .baud16_tick       (baud16_tick),
        .bit_tick          (bit_tick),
        .period            (period),
        .period_valid      (period_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: ticks fall at entry + k*interval while running.
    int unsigned last_div = 0;
    int          exp_start_at = -1;
    bit          engaged = 0, stale = 0, run_on = 0, pend_entry = 0;
    int          entry = 0, drop_cyc = 0, run_div = 0, run_per = 0;
    int unsigned m_mcand = 0, m_lat = 0, starts = 0;
    int unsigned lat_lo = 0, lat_hi = 3;

    typedef struct {
        int unsigned div;
        int unsigned period;
        int unsigned starts;
        int unsigned baud_cnt;
        int unsigned bit_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit eb, et;
        @(negedge clk);
        cyc++;
        if (pend_entry && cyc == drop_cyc + 1) begin
            pend_entry = 0;
            run_on     = 1;
            entry      = cyc;
            run_div    = int'(last_div);
            run_per    = int'(last_div * OS);
        end
        eb = run_on && run_div > 0 && cyc > entry && ((cyc - entry) % run_div) == 0;
        et = run_on && run_per > 0 && cyc > entry && ((cyc - entry) % run_per) == 0;
        chk("baud16_tick", baud16_tick, eb);
        chk("bit_tick", bit_tick, et);
        chk("period_valid", period_valid, run_on);
        if (run_on) chk("period", period, run_per);
        chk("mult_start", mult_start, cyc == exp_start_at);
        chk("mult_multiplier", mult_multiplier, OS);
        // External multiplier stand-in.
        if (mult_busy) begin
            if (m_lat == 0) begin
                mult_busy    = 1'b0;
                mult_product = PW'(m_mcand * OS);
                if (stale) begin
                    stale = 0;
                    if (last_div != 0) exp_start_at = cyc + 1;
                    else engaged = 0;
                end else begin
                    engaged    = 0;
                    pend_entry = 1;
                    drop_cyc   = cyc;
                end
            end else begin
                m_lat--;
                mult_product = PW'($urandom);
            end
        end else if (mult_start) begin
            chk("mult_multiplicand", mult_multiplicand, last_div);
            m_mcand      = mult_multiplicand;
            starts++;
            mult_busy    = 1'b1;
            m_lat        = $urandom_range(lat_hi, lat_lo);
            mult_product = PW'($urandom);
        end
        div_wr = 1'b0;
`ifdef BAUD_GEN_RESYNC_EN
        resync = 1'b0;
`endif
    endtask

    task automatic write_div(input int unsigned d);
        divisor    = DW'(d);
        div_wr     = 1'b1;
        last_div   = d;
        run_on     = 0;
        pend_entry = 0;
        if (engaged && exp_start_at == cyc + 1) begin
            if (d == 0) begin
                engaged      = 0;
                exp_start_at = -1;
            end
        end else if (engaged) begin
            stale = 1;
        end else if (d != 0) begin
            engaged      = 1;
            exp_start_at = cyc + 1;
        end
    endtask

`ifdef BAUD_GEN_RESYNC_EN
    task automatic do_resync();
        resync = 1'b1;
        if (run_on && !div_wr) entry = cyc + 1;
    endtask
`endif

    task automatic apply_reset(input int unsigned n);
        rst_n = 1'b0;
        #1;
        chk("rst_baud16_tick", baud16_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_period", period, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_multiplicand", mult_multiplicand, 0);
        run_on = 0; pend_entry = 0; engaged = 0; stale = 0;
        exp_start_at = -1; last_div = 0;
        mult_busy = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int unsigned limit);
        int unsigned n = 0;
        while (!period_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic count_ticks(input int unsigned len, output int unsigned bc, output int unsigned tc);
        bc = 0; tc = 0;
        repeat (len) begin
            step();
            if (baud16_tick) bc++;
            if (bit_tick) tc++;
        end
    endtask

    initial begin
        int unsigned bc, tc, n, r;
        rst_n = 1'b0; divisor = '0; div_wr = 1'b0;
        mult_busy = 1'b0; mult_product = '0;
`ifdef BAUD_GEN_RESYNC_EN
        resync = 1'b0;
`endif
        step();
        apply_reset(3);

        vecs[0] = '{3, 48, 1, 33, 2};
        vecs[1] = '{1, 16, 1, 100, 6};
        vecs[2] = '{0, 0, 0, 0, 0};
        vecs[3] = '{7, 112, 1, 14, 0};
        vecs[4] = '{2, 32, 1, 50, 3};
        for (int i = 0; i < 5; i++) begin
            apply_reset(2);
            starts = 0;
            write_div(vecs[i].div);
            step();
            wait_valid(50);
            chk("tbl_period_valid", period_valid, vecs[i].div != 0);
            chk("tbl_period", period, vecs[i].period);
            count_ticks(100, bc, tc);
            chk("tbl_baud_count", bc, vecs[i].baud_cnt);
            chk("tbl_bit_count", tc, vecs[i].bit_cnt);
            chk("tbl_starts", starts, vecs[i].starts);
        end

        // Rewrite while the multiplier is busy: last divisor wins.
        apply_reset(2);
        starts = 0; lat_lo = 3; lat_hi = 5;
        write_div(3);
        step();
        write_div(5);
        step();
        wait_valid(60);
        chk("rewrite_period", period, 80);
        chk("rewrite_starts", starts, 2);
        count_ticks(160, bc, tc);
        chk("rewrite_baud_count", bc, 32);
        chk("rewrite_bit_count", tc, 2);
        lat_lo = 0; lat_hi = 3;

        // Reset ten cycles into RUN, then restart.
        apply_reset(2);
        write_div(3);
        step();
        wait_valid(50);
        repeat (10) step();
        apply_reset(3);
        starts = 0;
        write_div(4);
        step();
        wait_valid(50);
        chk("restart_period", period, 64);
        count_ticks(64, bc, tc);
        chk("restart_baud_count", bc, 16);
        chk("restart_bit_count", tc, 1);

        // Writes during RUN: nonzero re-requests, zero parks in IDLE.
        write_div(6);
        step();
        wait_valid(50);
        chk("run_write_period", period, 96);
        chk("run_write_starts", starts, 2);
        write_div(0);
        repeat (20) step();
        chk("run_zero_valid", period_valid, 0);
        chk("run_zero_starts", starts, 2);

`ifdef BAUD_GEN_RESYNC_EN
        apply_reset(2);
        write_div(4);
        step();
        wait_valid(50);
        n = 0;
        while (!baud16_tick && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        do_resync();
        step();
        n = 0;
        do begin
            step();
            n++;
        end while (!baud16_tick && n < 20);
        chk("resync_gap", n, 4);
`endif

        // Randomized writes, resyncs and resets.
        apply_reset(2);
        lat_hi = 4;
        repeat (3000) begin
            r = $urandom_range(999, 0);
            if (r < 25) begin
                write_div(($urandom_range(7, 0) == 0) ? 0 : $urandom_range(9, 1));
`ifdef BAUD_GEN_RESYNC_EN
            end else if (r < 45) begin
                do_resync();
`endif
            end else if (r == 999) begin
                apply_reset(1);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
